// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver, 8N1 frames by default.
// Define UART_RX_PARITY_EN to build the PARITY state (8E1 frames) and drive parity_err.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int MID_SAMPLE = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clk_16bd,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif
  localparam logic [2:0] STOP   = 3'd4;

  localparam logic [3:0] MID_TCNT  = 4'(MID_SAMPLE);
  localparam logic [3:0] LAST_TCNT = 4'd15;
  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);

  logic                 rx_meta_reg;
  logic                 rx_sync_reg;
  logic                 clk16_prev_reg;
  logic                 tick;

  logic [2:0]           state_reg, state_next;
  logic [3:0]           tcnt_reg, tcnt_next;
  logic [2:0]           bcnt_reg, bcnt_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic [DATA_BITS-1:0] shift_in;
  logic [DATA_BITS-1:0] data_reg, data_next;
  logic                 data_valid_reg, data_valid_next;
  logic                 frame_err_reg, frame_err_next;
`ifdef UART_RX_PARITY_EN
  logic                 parity_bit_reg, parity_bit_next;
  logic                 parity_err_reg, parity_err_next;
`endif

  // rx is asynchronous; the synchronizer idles high so reset never looks like a start bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_reg    <= 1'b1;
      rx_sync_reg    <= 1'b1;
      clk16_prev_reg <= 1'b0;
    end else begin
      rx_meta_reg    <= rx;
      rx_sync_reg    <= rx_meta_reg;
      clk16_prev_reg <= clk_16bd;
    end
  end

  assign tick = clk_16bd & ~clk16_prev_reg;

  // Right-shift: each new bit enters at the MSB, so the first (LSB) bit ends at bit 0
  genvar gi;
  generate
    for (gi = 0; gi < DATA_BITS; gi++) begin : g_shift
      if (gi == DATA_BITS - 1) begin : g_msb
        assign shift_in[gi] = rx_sync_reg;
      end else begin : g_body
        assign shift_in[gi] = shift_reg[gi+1];
      end
    end
  endgenerate

  always_comb begin
    state_next      = state_reg;
    tcnt_next       = tcnt_reg;
    bcnt_next       = bcnt_reg;
    shift_next      = shift_reg;
    data_next       = data_reg;
    data_valid_next = 1'b0;
    frame_err_next  = frame_err_reg;
`ifdef UART_RX_PARITY_EN
    parity_bit_next = parity_bit_reg;
    parity_err_next = parity_err_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (!rx_sync_reg) begin
          state_next = START;
          tcnt_next  = 4'd0;
        end
      end
      START: begin
        if (tick) begin
          if (tcnt_reg == MID_TCNT) begin
            tcnt_next = 4'd0;
            bcnt_next = 3'd0;
            // A start bit that is high again at its centre was a glitch
            state_next = rx_sync_reg ? IDLE : DATA;
          end else begin
            tcnt_next = tcnt_reg + 4'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          tcnt_next = tcnt_reg + 4'd1;
          if (tcnt_reg == LAST_TCNT) begin
            shift_next = shift_in;
            if (bcnt_reg == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state_next = PARITY;
`else
              state_next = STOP;
`endif
            end else begin
              bcnt_next = bcnt_reg + 3'd1;
            end
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          tcnt_next = tcnt_reg + 4'd1;
          if (tcnt_reg == LAST_TCNT) begin
            parity_bit_next = rx_sync_reg;
            state_next      = STOP;
          end
        end
      end
`endif
      STOP: begin
        if (tick) begin
          tcnt_next = tcnt_reg + 4'd1;
          // Leaving at mid-stop leaves half a bit to catch a back-to-back start edge
          if (tcnt_reg == LAST_TCNT) begin
            data_next       = shift_reg;
            data_valid_next = 1'b1;
            frame_err_next  = ~rx_sync_reg;
`ifdef UART_RX_PARITY_EN
            parity_err_next = parity_bit_reg ^ (^shift_reg);
`endif
            tcnt_next       = 4'd0;
            state_next      = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
        tcnt_next  = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      tcnt_reg       <= 4'd0;
      bcnt_reg       <= 3'd0;
      shift_reg      <= '0;
      data_reg       <= '0;
      data_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit_reg <= 1'b0;
      parity_err_reg <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      tcnt_reg       <= tcnt_next;
      bcnt_reg       <= bcnt_next;
      shift_reg      <= shift_next;
      data_reg       <= data_next;
      data_valid_reg <= data_valid_next;
      frame_err_reg  <= frame_err_next;
`ifdef UART_RX_PARITY_EN
      parity_bit_reg <= parity_bit_next;
      parity_err_reg <= parity_err_next;
`endif
    end
  end

  assign data       = data_reg;
  assign data_valid = data_valid_reg;
  assign frame_err  = frame_err_reg;
  assign busy       = (state_reg != IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_reg;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames into uart_rx with clk = 4 ns and clk_16bd = clk/8 (128 clk per bit).
// Define UART_RX_PARITY_EN for both files to exercise the 8E1 build.
module tb_uart_rx;
  localparam int BIT = 128;

  logic       clk      = 1'b0;
  logic       clk_16bd = 1'b0;
  logic       rst_n    = 1'b0;
  logic       rx       = 1'b1;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  int checks = 0;
  int passed = 0;

  logic [7:0] cap_data[$];
  logic       cap_ferr[$];
  logic       cap_perr[$];
  logic       cap_busy[$];
`ifdef UART_RX_PARITY_EN
  logic       par_flip = 1'b0;
`endif

  uart_rx dut (
    .clk       (clk),
    .rst       (rst_n),
    .clk_16bd  (clk_16bd),
    .rx        (rx),
    .data      (data),
    .data_valid(data_valid),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .busy      (busy)
  );

  always #2 clk = ~clk;
  always #16 clk_16bd = ~clk_16bd;

  // Record every cycle data_valid is high, so a stretched pulse shows up as extra entries
  always @(negedge clk) begin
    if (data_valid === 1'b1) begin
      cap_data.push_back(data);
      cap_ferr.push_back(frame_err);
      cap_perr.push_back(parity_err);
      cap_busy.push_back(busy);
      $display("rx frame: data=%h frame_err=%b parity_err=%b busy=%b", data, frame_err, parity_err, busy);
    end
  end

  task automatic clear_caps();
    cap_data.delete();
    cap_ferr.delete();
    cap_perr.delete();
    cap_busy.delete();
  endtask

  task automatic drive(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_ok);
    drive(1'b0, BIT);
    for (int i = 0; i < 8; i++) drive(b[i], BIT);
`ifdef UART_RX_PARITY_EN
    drive((^b) ^ par_flip, BIT);
`endif
    if (stop_ok) begin
      drive(1'b1, BIT);
    end else begin
      drive(1'b0, 96);
      rx = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (data !== 8'h00) $display("FAIL reset_data: got %h expected 00", data); else passed++;
    checks++; if (data_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", data_valid); else passed++;
    checks++; if (frame_err !== 1'b0) $display("FAIL reset_ferr: got %b expected 0", frame_err); else passed++;
    checks++; if (parity_err !== 1'b0) $display("FAIL reset_perr: got %b expected 0", parity_err); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
    rst_n = 1'b1;
    drive(1'b1, 40);
  endtask

  task automatic test_single();
    clear_caps();
    send_frame(8'h55, 1'b1);
    drive(1'b1, 200);
    @(negedge clk);
    checks++; if (cap_data.size() !== 1) $display("FAIL single_count: got %0d expected 1", cap_data.size()); else passed++;
    checks++; if (((cap_data.size() > 0) ? cap_data[0] : 8'hxx) !== 8'h55) $display("FAIL single_data: got %h expected 55", (cap_data.size() > 0) ? cap_data[0] : 8'hxx); else passed++;
    checks++; if (((cap_ferr.size() > 0) ? cap_ferr[0] : 1'bx) !== 1'b0) $display("FAIL single_ferr: got %b expected 0", (cap_ferr.size() > 0) ? cap_ferr[0] : 1'bx); else passed++;
    checks++; if (((cap_perr.size() > 0) ? cap_perr[0] : 1'bx) !== 1'b0) $display("FAIL single_perr: got %b expected 0", (cap_perr.size() > 0) ? cap_perr[0] : 1'bx); else passed++;
    checks++; if (((cap_busy.size() > 0) ? cap_busy[0] : 1'bx) !== 1'b0) $display("FAIL single_busy_at_valid: got %b expected 0", (cap_busy.size() > 0) ? cap_busy[0] : 1'bx); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL single_busy_after: got %b expected 0", busy); else passed++;
    checks++; if (data !== 8'h55) $display("FAIL single_data_held: got %h expected 55", data); else passed++;
  endtask

  task automatic test_back_to_back();
    clear_caps();
    send_frame(8'hA3, 1'b1);
    send_frame(8'h0F, 1'b1);
    drive(1'b1, 200);
    @(negedge clk);
    checks++; if (cap_data.size() !== 2) $display("FAIL b2b_count: got %0d expected 2", cap_data.size()); else passed++;
    checks++; if (((cap_data.size() > 0) ? cap_data[0] : 8'hxx) !== 8'hA3) $display("FAIL b2b_first: got %h expected a3", (cap_data.size() > 0) ? cap_data[0] : 8'hxx); else passed++;
    checks++; if (((cap_data.size() > 1) ? cap_data[1] : 8'hxx) !== 8'h0F) $display("FAIL b2b_second: got %h expected 0f", (cap_data.size() > 1) ? cap_data[1] : 8'hxx); else passed++;
    checks++; if (((cap_ferr.size() > 1) ? cap_ferr[1] : 1'bx) !== 1'b0) $display("FAIL b2b_ferr: got %b expected 0", (cap_ferr.size() > 1) ? cap_ferr[1] : 1'bx); else passed++;
  endtask

  task automatic test_false_start();
    clear_caps();
    drive(1'b0, 8);
    @(negedge clk);
    checks++; if (busy !== 1'b1) $display("FAIL false_start_busy_rise: got %b expected 1", busy); else passed++;
    drive(1'b0, 24);
    drive(1'b1, 150);
    @(negedge clk);
    checks++; if (busy !== 1'b0) $display("FAIL false_start_busy_fall: got %b expected 0", busy); else passed++;
    checks++; if (cap_data.size() !== 0) $display("FAIL false_start_count: got %0d expected 0", cap_data.size()); else passed++;
  endtask

  task automatic test_frame_error();
    clear_caps();
    send_frame(8'h3C, 1'b0);
    drive(1'b1, 300);
    @(negedge clk);
    checks++; if (cap_data.size() !== 1) $display("FAIL ferr_count: got %0d expected 1", cap_data.size()); else passed++;
    checks++; if (((cap_data.size() > 0) ? cap_data[0] : 8'hxx) !== 8'h3C) $display("FAIL ferr_data: got %h expected 3c", (cap_data.size() > 0) ? cap_data[0] : 8'hxx); else passed++;
    checks++; if (((cap_ferr.size() > 0) ? cap_ferr[0] : 1'bx) !== 1'b1) $display("FAIL ferr_flag: got %b expected 1", (cap_ferr.size() > 0) ? cap_ferr[0] : 1'bx); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL ferr_busy: got %b expected 0", busy); else passed++;
    clear_caps();
    send_frame(8'h5A, 1'b1);
    drive(1'b1, 200);
    @(negedge clk);
    checks++; if (((cap_data.size() > 0) ? cap_data[0] : 8'hxx) !== 8'h5A) $display("FAIL ferr_next_data: got %h expected 5a", (cap_data.size() > 0) ? cap_data[0] : 8'hxx); else passed++;
    checks++; if (frame_err !== 1'b0) $display("FAIL ferr_cleared: got %b expected 0", frame_err); else passed++;
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b;
    b = 8'h81;
    clear_caps();
    drive(1'b0, BIT);
    for (int i = 0; i < 4; i++) drive(b[i], BIT);
    drive(b[4], 64);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (data !== 8'h00) $display("FAIL midreset_data: got %h expected 00", data); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL midreset_busy: got %b expected 0", busy); else passed++;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 300);
    @(negedge clk);
    checks++; if (cap_data.size() !== 0) $display("FAIL midreset_no_valid: got %0d expected 0", cap_data.size()); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL midreset_idle: got %b expected 0", busy); else passed++;
    send_frame(8'h7E, 1'b1);
    drive(1'b1, 200);
    @(negedge clk);
    checks++; if (cap_data.size() !== 1) $display("FAIL midreset_next_count: got %0d expected 1", cap_data.size()); else passed++;
    checks++; if (data !== 8'h7E) $display("FAIL midreset_next_data: got %h expected 7e", data); else passed++;
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    clear_caps();
    par_flip = 1'b0;
    send_frame(8'h07, 1'b1);
    drive(1'b1, 200);
    @(negedge clk);
    checks++; if (((cap_perr.size() > 0) ? cap_perr[0] : 1'bx) !== 1'b0) $display("FAIL parity_good: got %b expected 0", (cap_perr.size() > 0) ? cap_perr[0] : 1'bx); else passed++;
    clear_caps();
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1);
    drive(1'b1, 200);
    @(negedge clk);
    par_flip = 1'b0;
    checks++; if (((cap_perr.size() > 0) ? cap_perr[0] : 1'bx) !== 1'b1) $display("FAIL parity_bad: got %b expected 1", (cap_perr.size() > 0) ? cap_perr[0] : 1'bx); else passed++;
    checks++; if (((cap_data.size() > 0) ? cap_data[0] : 8'hxx) !== 8'h07) $display("FAIL parity_bad_data: got %h expected 07", (cap_data.size() > 0) ? cap_data[0] : 8'hxx); else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_false_start();
    test_frame_error();
    test_reset_midframe();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver for the serial link: recovers 8N1 frames (optionally 8E1) from the asynchronous `rx` line using the 16x-oversampling enable `clk_16bd` produced by `clock_handler`. It is the receiving end of the link whose transmit side shifts frames at `clk_bd`. Each received byte is presented on `data` with a one-cycle `data_valid` strobe and per-frame error flags.

## Interface
- `DATA_BITS`, default 8: payload bits per frame, LSB first. Legal values are 5 to 8.
- `MID_SAMPLE`, default 7: oversample tick index, 0..15, at which each bit is sampled.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-low reset.
- `clk_16bd` in 1: 16x baud clock from `clock_handler`, synchronous to `clk`. Only its rising edge is used.
- `rx` in 1: serial line. Idles high. Asynchronous to `clk`.
- `data` out DATA_BITS: last received payload. Held until the next frame completes.
- `data_valid` out 1: one-`clk` pulse when a frame completes.
- `frame_err` out 1: stop bit sampled low. Updated with `data_valid`.
- `parity_err` out 1: parity mismatch. Present only with `UART_RX_PARITY_EN`. Updated with `data_valid`.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
**Input conditioning**
- `rx` passes through a 2-flop synchronizer; the synchronizer resets to 1.
- `tick` is a 1-cycle pulse on each rising edge of `clk_16bd`, taken from a registered previous value that resets to 0.

**State machine**
- IDLE:
  - Synchronized `rx` = 0 moves to START and clears `tcnt` (4 bits).
  - This transition is not gated by `tick`.
- START:
  - `tcnt` increments on each `tick`.
  - At `tick` with `tcnt == MID_SAMPLE`: if `rx` = 1, it is a false start and the state returns to IDLE. Otherwise go to DATA with `tcnt` = 0 and `bcnt` = 0.
- DATA:
  - At `tick` with `tcnt == 15`: shift `rx` into the MSB of the shift register (right-shift, LSB first).
  - If `bcnt == DATA_BITS-1`, go to PARITY (macro) or STOP; otherwise increment `bcnt`.
  - `tcnt` wraps 15 -> 0.
- PARITY (macro only): sample at `tcnt == 15`, then go to STOP.
- STOP:
  - At `tick` with `tcnt == 15`, sample the stop bit.
  - Next edge: `data` <= shift register, `data_valid` = 1, `frame_err` = ~stop, `parity_err` updated, state = IDLE.
  - Returning to IDLE at mid-stop allows a back-to-back start edge to be caught.
- Because sampling begins at mid-start and advances 16 ticks per bit, every data bit is sampled at its centre.

**Other rules**
- `clk_16bd` inactive: FSM freezes in its current state. There is no timeout.
- Reset (asynchronous, any time including mid-frame):
  - State = IDLE, counters = 0, shift register = 0.
  - `data` = 0, `data_valid` = 0, `frame_err` = 0, `parity_err` = 0, `busy` = 0.
  - A partial frame is discarded with no `data_valid`.
- Error flags do not suppress the frame: `data_valid` still pulses and `data` still loads.
- There is no back-pressure: a consumer that misses `data` before the next `data_valid` loses it.

## Timing
- `rx` to internal edge detection: 2 `clk`.
- Start detection to first sample: MID_SAMPLE+1 ticks.
- Each later sample: 16 ticks after the previous one.
- `data_valid` rises 1 `clk` after the `tick` that samples the stop bit. It is high for exactly 1 `clk`.
- `busy` rises 1 `clk` after synchronized `rx` falls. It falls in the same cycle `data_valid` rises.
- A `tick` on the same `clk` as reset release is ignored.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - PARITY state is built in and the frame is 8E1.
  - Received bit is compared against XOR of the payload (even parity).
  - `parity_err` = 1 on mismatch.
  - Frame length is 11 bit times.
- Not defined:
  - No PARITY state; the frame is 8N1.
  - `parity_err` is a constant 0.

## Test plan
- Reset, `clk` period 4 ns, `clk_16bd` = `clk`/8. Send 0x55 8N1 -> one `data_valid` pulse, `data` = 0x55, `frame_err` = 0, `busy` low afterwards.
- Send 0xA3 immediately followed by 0x0F, no idle gap -> two pulses with `data` = 0xA3 then 0x0F.
- Pull `rx` low for 4 ticks, then high -> no `data_valid`, and `busy` returns to 0 after the mid-start sample.
- Send 0x3C with stop bit = 0 -> `data` = 0x3C, `frame_err` = 1. The next good frame clears `frame_err` to 0.
- Assert `rst` low during bit 4 of 0x81, then release and send 0x7E -> no pulse for the aborted frame, then `data` = 0x7E.
- With `UART_RX_PARITY_EN`:
  - Send 0x07 with parity bit 1 -> `parity_err` = 0.
  - Send 0x07 with parity bit 0 -> `parity_err` = 1.
